// File: rtl/counter.sv
// Enable-gated up-counter with a configurable modulus and an asynchronous active-low clear.
// cout runs 0..MODULUS-1 and wraps to 0; it is driven straight from a register.
module counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] cout
);

    // Modulus held at WIDTH+1 bits so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W = MODULUS[WIDTH:0];

    logic [WIDTH-1:0] cout_q;
    logic [WIDTH-1:0] cout_d;
    logic [WIDTH:0]   incr;

    always_comb begin
        incr   = {1'b0, cout_q} + {{WIDTH{1'b0}}, 1'b1};
        cout_d = cout_q;
        if (enable) begin
            cout_d = (incr == MOD_W) ? '0 : incr[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cout_q <= '0;
        end else begin
            cout_q <= cout_d;
        end
    end

    assign cout = cout_q;

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter: a default (mod 16) and a mod-10 instance
// run side by side against modulo-arithmetic reference counts.
module tb_counter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] cout16;
    logic [3:0] cout10;

    int n_cmp;
    int n_bad;
    int m16;
    int m10;

    counter #(.WIDTH(4)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .cout   (cout16)
    );

    counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .cout   (cout10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
        end else begin
            $display("ok   %s at t=%0t: %0d", tag, $time, obs);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/mod16"}, {28'd0, cout16}, m16);
        check({tag, "/mod10"}, {28'd0, cout10}, m10);
    endtask

    // One rising edge; the reference advances by the sampled inputs, then both outputs are checked.
    task automatic tick(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst && enable) begin
                m16 = (m16 + 1) % 16;
                m10 = (m10 + 1) % 10;
            end
            #1;
            check_both(tag);
        end
    endtask

    // Reset pulse placed between edges; output must clear before any edge arrives.
    task automatic async_clear(input string tag);
        #3;
        rst = 1'b0;
        m16 = 0;
        m10 = 0;
        #1;
        check_both(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m16    = 0;
        m10    = 0;
        rst    = 1'b1;
        enable = 1'b0;

        // Power-up clear before the first edge, then held across edges.
        #2 rst = 1'b0;
        #1 check_both("powerup");
        tick("rst_hold", 1);

        // Reset dominance over enable.
        enable = 1'b1;
        tick("rst_dom", 3);

        // Release and hold with enable low.
        enable = 1'b0;
        rst    = 1'b1;
        tick("hold0", 2);

        // Count 10 edges then hold.
        enable = 1'b1;
        tick("count", 10);
        check("count_ten", {28'd0, cout16}, 32'd10);
        enable = 1'b0;
        tick("hold10", 3);

        // Wrap from 0 over 17 edges.
        async_clear("clr_wrap");
        enable = 1'b1;
        tick("wrap", 17);
        check("wrap_end16", {28'd0, cout16}, 32'd1);
        check("wrap_end10", {28'd0, cout10}, 32'd7);

        // Async reset mid-count at 7, then resume from 0.
        async_clear("clr_pre");
        tick("to7", 7);
        check("at7", {28'd0, cout16}, 32'd7);
        async_clear("mid_clr");
        tick("resume", 1);
        check("resume1", {28'd0, cout16}, 32'd1);

        // Random enable with occasional mid-cycle reset pulses.
        for (int k = 0; k < 300; k++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                async_clear("rnd_clr");
            end
            tick("rnd", 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
